// File: rtl/pwm_pkg.sv
// Shared constants and the per-output drive function for the PWM output stage.
// Both the output stage and its bench model use output_mux().
package pwm_pkg;

    localparam int PWM_CNT_W            = 8;
    localparam int NUM_OUTS             = 16;
    localparam int DEFAULT_PRESCALE_DIV = 13;

    // A disabled output is low, a static one is high, and a PWM one follows pwm_sig.
    function automatic logic [NUM_OUTS-1:0] output_mux(
        input logic [NUM_OUTS-1:0] en_out,
        input logic [NUM_OUTS-1:0] en_pwm,
        input logic                pwm_sig
    );
        logic [NUM_OUTS-1:0] result;
        result = '0;
        for (int i = 0; i < NUM_OUTS; i++) begin
            result[i] = en_out[i] & (en_pwm[i] ? pwm_sig : 1'b1);
        end
        return result;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler, 8-bit PWM counter and period-load generation.
// The first edge after reset always loads, so every period starts with a fresh duty.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int PRESCALE_DIV = DEFAULT_PRESCALE_DIV
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [PWM_CNT_W-1:0] pwm_cnt,
    output logic                 tick,
    output logic                 load
);

    localparam int PRE_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE_DIV - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic             started;

    assign tick = (pre_cnt == PRE_MAX);
    assign load = !started || (tick && (pwm_cnt == '1));

    // pwm_cnt only advances once started, so it still reads 0 after the post-reset load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
            started <= 1'b0;
        end else begin
            started <= 1'b1;
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (started && tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_output_stage.sv
// Drives 16 chip outputs low, static high, or with a shared PWM waveform.
// The duty cycle is captured only at period boundaries so each period is glitch-free.
module pwm_output_stage
    import pwm_pkg::*;
#(
    parameter int PRESCALE_DIV = DEFAULT_PRESCALE_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] en_reg_out_7_0,
    input  logic [7:0] en_reg_out_15_8,
    input  logic [7:0] en_reg_pwm_7_0,
    input  logic [7:0] en_reg_pwm_15_8,
    input  logic [7:0] pwm_duty_cycle,
    output logic [7:0] out_7_0,
    output logic [7:0] out_15_8,
    output logic       period_start
);

    logic [PWM_CNT_W-1:0] pwm_cnt;
    logic                 tick;
    logic                 load;
    logic [PWM_CNT_W-1:0] duty_sh;
    logic                 pwm_sig;
    logic [NUM_OUTS-1:0]  en_out;
    logic [NUM_OUTS-1:0]  en_pwm;
    logic [NUM_OUTS-1:0]  out_next;

    pwm_timebase #(
        .PRESCALE_DIV (PRESCALE_DIV)
    ) u_timebase (
        .clk     (clk),
        .rst_n   (rst_n),
        .pwm_cnt (pwm_cnt),
        .tick    (tick),
        .load    (load)
    );

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // 0xFF is forced fully on; 255/256 duty is deliberately not representable.
    assign pwm_sig  = (duty_sh == '1) || (pwm_cnt < duty_sh);
    assign out_next = output_mux(en_out, en_pwm, pwm_sig);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_sh      <= '0;
            period_start <= 1'b0;
            out_7_0      <= '0;
            out_15_8     <= '0;
        end else begin
            if (load) begin
                duty_sh <= pwm_duty_cycle;
            end
            period_start <= load;
            out_7_0      <= out_next[7:0];
            out_15_8     <= out_next[15:8];
        end
    end

    // The PWM counter may only move on a prescaler tick.
    assert property (@(posedge clk) disable iff (!rst_n) !tick |=> $stable(pwm_cnt));

endmodule

// File: tb/tb_pwm_output_stage.sv
// Scoreboard bench for pwm_output_stage with a 4-cycle prescaler (1024-cycle period).
// A cycle model pushes the expected outputs at each edge; checks pop them on the next falling edge.
module tb_pwm_output_stage;
    import pwm_pkg::*;

    localparam int DIV    = 4;
    localparam int PERIOD = 256 * DIV;
    localparam int POS_W  = $clog2(PERIOD);

    logic       clk;
    logic       rst_n;
    logic [7:0] out_7_0;
    logic [7:0] out_15_8;
    logic       period_start;

    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;

    typedef struct packed {
        logic [15:0] outs;
        logic        ps;
    } exp_t;

    exp_t exp_q[$];

    logic             m_started;
    logic [POS_W-1:0] m_pos;
    logic [7:0]       m_duty;

    int total;
    int bad;
    int len_cnt;
    int hi_cnt;

    pwm_output_stage #(
        .PRESCALE_DIV (DIV)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_out[7:0]),
        .en_reg_out_15_8 (en_out[15:8]),
        .en_reg_pwm_7_0  (en_pwm[7:0]),
        .en_reg_pwm_15_8 (en_pwm[15:8]),
        .pwm_duty_cycle  (duty),
        .out_7_0         (out_7_0),
        .out_15_8        (out_15_8),
        .period_start    (period_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // m_pos is the clock position inside the 1024-cycle period; the counter value is m_pos/4.
    function automatic logic model_load();
        return !m_started || (m_pos == POS_W'(PERIOD - 1));
    endfunction

    function automatic logic model_sig();
        return (m_duty == 8'hFF) || (m_pos[POS_W-1:2] < m_duty);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_started <= 1'b0;
            m_pos     <= '0;
            m_duty    <= 8'h00;
            exp_q.delete();
        end else begin
            exp_q.push_back('{outs: output_mux(en_out, en_pwm, model_sig()), ps: model_load()});
            m_started <= 1'b1;
            m_pos     <= m_pos + 1'b1;
            if (model_load()) begin
                m_duty <= duty;
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        en_out = eo;
        en_pwm = ep;
        duty   = d;
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        total++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else if (!rst_n) begin
            e = '0;
        end else begin
            bad++;
            $error("[TB] FAIL %s: no expected entry, observed outs=%h ps=%b", tag,
                   {out_15_8, out_7_0}, period_start);
            return;
        end
        assert ({out_15_8, out_7_0, period_start} === e) else begin
            bad++;
            $error("[TB] FAIL %s: observed outs=%h ps=%b expected outs=%h ps=%b", tag,
                   {out_15_8, out_7_0}, period_start, e.outs, e.ps);
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic stepCycle();
        @(negedge clk);
        checkOutput("scoreboard");
        len_cnt++;
        if (out_7_0[0] === 1'b1) hi_cnt++;
    endtask

    task automatic clearCounters();
        len_cnt = 0;
        hi_cnt  = 0;
    endtask

    task automatic waitPeriodStart();
        int budget;
        budget = 0;
        do begin
            stepCycle();
            budget++;
        end while (period_start !== 1'b1 && budget < 2 * PERIOD);
        checkValue("period_start_seen", {31'd0, period_start}, 32'd1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clearCounters();
        rst_n = 1'b0;
        applyStimulus(16'hFFFF, 16'hFFFF, 8'hFF);
        $display("[TB] starting pwm_output_stage bench");

        repeat (3) stepCycle();
        checkValue("reset_outs", {16'd0, out_15_8, out_7_0}, 32'd0);
        checkValue("reset_period_start", {31'd0, period_start}, 32'd0);

        rst_n = 1'b1;
        stepCycle();
        checkValue("first_period_start", {31'd0, period_start}, 32'd1);
        stepCycle();
        checkValue("period_start_one_cycle", {31'd0, period_start}, 32'd0);
        waitPeriodStart();
        clearCounters();
        waitPeriodStart();
        checkValue("period_length", len_cnt, PERIOD);
        checkValue("duty_ff_never_low", hi_cnt, PERIOD);

        applyStimulus(16'h8001, 16'h0000, 8'h80);
        stepCycle();
        checkValue("static_out_7_0", {24'd0, out_7_0}, 32'h01);
        checkValue("static_out_15_8", {24'd0, out_15_8}, 32'h80);
        repeat (3) waitPeriodStart();
        checkValue("static_hold", {16'd0, out_15_8, out_7_0}, 32'h8001);

        applyStimulus(16'hFFFF, 16'hFFFF, 8'h80);
        waitPeriodStart();
        checkValue("pwm_low_at_period_start", {16'd0, out_15_8, out_7_0}, 32'h0000);
        clearCounters();
        stepCycle();
        checkValue("pwm_rise_after_start", {16'd0, out_15_8, out_7_0}, 32'hFFFF);
        waitPeriodStart();
        checkValue("duty_80_high", hi_cnt, PERIOD / 2);
        checkValue("duty_80_length", len_cnt, PERIOD);

        applyStimulus(16'hFFFF, 16'hFFFF, 8'h00);
        waitPeriodStart();
        clearCounters();
        waitPeriodStart();
        checkValue("duty_00_never_high", hi_cnt, 0);
        applyStimulus(16'hFFFF, 16'h00FF, 8'h00);
        stepCycle();
        checkValue("mixed_static_hi", {24'd0, out_15_8}, 32'hFF);
        checkValue("mixed_pwm_lo", {24'd0, out_7_0}, 32'h00);

        applyStimulus(16'hFFFF, 16'hFFFF, 8'h40);
        waitPeriodStart();
        clearCounters();
        repeat (500) stepCycle();
        applyStimulus(16'hFFFF, 16'hFFFF, 8'hC0);
        waitPeriodStart();
        checkValue("dbuf_current_period", hi_cnt, 256);
        clearCounters();
        waitPeriodStart();
        checkValue("dbuf_next_period", hi_cnt, 768);

        applyStimulus(16'hFFFF, 16'hFFFF, 8'hFF);
        waitPeriodStart();
        repeat (400) stepCycle();
        checkValue("high_before_reset", {16'd0, out_15_8, out_7_0}, 32'hFFFF);
        #3 rst_n = 1'b0;
        #1;
        checkValue("async_reset_outs", {16'd0, out_15_8, out_7_0}, 32'h0000);
        checkValue("async_reset_ps", {31'd0, period_start}, 32'd0);
        applyStimulus(16'hFFFF, 16'hFFFF, 8'h20);
        repeat (3) stepCycle();
        rst_n = 1'b1;
        stepCycle();
        checkValue("restart_period_start", {31'd0, period_start}, 32'd1);
        stepCycle();
        checkValue("restart_duty_reloaded", {16'd0, out_15_8, out_7_0}, 32'hFFFF);
        waitPeriodStart();
        clearCounters();
        waitPeriodStart();
        checkValue("duty_20_high", hi_cnt, 128);
        checkValue("duty_20_length", len_cnt, PERIOD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
